// File: rtl/ece385_vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ece385_vga_pkg
// Brief    : Shared register map and edge-type encodings for the VGA engine
//            Avalon-MM status/control ports.
// Revision : 1.0 - initial release
// ============================================================================
package ece385_vga_pkg;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
  localparam logic [1:0] ADDR_RESERVED = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  localparam int BUS_W = 32;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_ANY  = 2'd2
  } edge_type_e;

endpackage
`default_nettype wire

// File: rtl/ece385_sync_vec.sv
`default_nettype none
// ============================================================================
// Module   : ece385_sync_vec
// Brief    : Reset-to-zero flop-chain synchroniser for a vector of
//            asynchronous inputs; dout lags din by SYNC_STAGES clocks.
// Revision : 1.0 - initial release
// ============================================================================
module ece385_sync_vec #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // r_chain[0] is the metastability-exposed stage; the last stage is the output
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], din};
    end
  end

  assign dout = r_chain[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/ece385_vga_status_in.sv
`default_nettype none
// ============================================================================
// Module   : ece385_vga_status_in
// Brief    : Avalon-MM status input port with synchroniser, armed edge
//            detection and sticky write-1-to-clear edge capture. Interrupt
//            mask and irq output exist only with ECE385_VGA_STATUS_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ece385_vga_status_in
  import ece385_vga_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port
`ifdef ECE385_VGA_STATUS_IRQ_EN
  ,
  output logic             irq
`endif
);

  localparam int                 c_arm_w   = $clog2(SYNC_STAGES + 2);
  localparam logic [c_arm_w-1:0] c_arm_max = c_arm_w'(SYNC_STAGES + 1);

  logic [WIDTH-1:0]   w_sync;
  logic [WIDTH-1:0]   r_prev;
  logic [WIDTH-1:0]   r_edgecap;
  logic [WIDTH-1:0]   w_edge_raw;
  logic [WIDTH-1:0]   w_edge;
  logic [WIDTH-1:0]   w_clr;
  logic [WIDTH-1:0]   w_mask_rd;
  logic [c_arm_w-1:0] r_arm_cnt;
  logic               w_armed;
  logic               w_rd_en;
  logic               w_wr_en;
  logic [BUS_W-1:0]   w_rd_mux;
  logic               w_unused_bits;

  ece385_sync_vec #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (in_port),
    .dout    (w_sync)
  );

  assign w_rd_en = chipselect & ~read_n;
  assign w_wr_en = chipselect & ~write_n;

  // Arming holds off detection until the chain has flushed its reset zeros,
  // so inputs already high at reset release do not look like rising edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= '0;
      r_prev    <= '0;
    end else begin
      if (r_arm_cnt != c_arm_max) begin
        r_arm_cnt <= r_arm_cnt + c_arm_w'(1);
      end
      r_prev <= w_sync;
    end
  end

  assign w_armed = (r_arm_cnt == c_arm_max);

  generate
    if (EDGE_TYPE == int'(EDGE_FALL)) begin : g_edge_fall
      assign w_edge_raw = ~w_sync & r_prev;
    end else if (EDGE_TYPE == int'(EDGE_ANY)) begin : g_edge_any
      assign w_edge_raw = w_sync ^ r_prev;
    end else begin : g_edge_rise
      assign w_edge_raw = w_sync & ~r_prev;
    end
  endgenerate

  assign w_edge = w_armed ? w_edge_raw : '0;
  assign w_clr  = (w_wr_en && (address == ADDR_EDGECAP)) ? writedata[WIDTH-1:0] : '0;

  // Clear is applied before the new edge is OR'd in, so a coincident edge survives
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edgecap <= '0;
    end else begin
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
    end
  end

`ifdef ECE385_VGA_STATUS_IRQ_EN
  logic [WIDTH-1:0] r_irqmask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask <= '0;
    end else if (w_wr_en && (address == ADDR_IRQMASK)) begin
      r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  assign w_mask_rd = r_irqmask;
  assign irq       = |(r_edgecap & r_irqmask);
`else
  assign w_mask_rd = '0;
`endif

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_DATA:     w_rd_mux = BUS_W'(w_sync);
      ADDR_IRQMASK:  w_rd_mux = BUS_W'(w_mask_rd);
      ADDR_RESERVED: w_rd_mux = '0;
      ADDR_EDGECAP:  w_rd_mux = BUS_W'(r_edgecap);
      default:       w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else if (w_rd_en) begin
      readdata <= w_rd_mux;
    end
  end

  // Upper writedata bits are meaningless when WIDTH < 32
  assign w_unused_bits = &{1'b0, writedata};

endmodule
`default_nettype wire
